// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage enable/flush sequencing for load-use, branch, mult/div and memory-wait hazards
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             md_start,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);
  localparam int MDW = $clog2(MD_LATENCY);
  localparam logic [MDW-1:0] MD_INIT = MDW'(MD_LATENCY - 1);
  localparam logic [1:0] RUN = 2'd0, MD_WAIT = 2'd1, MEM_WAIT = 2'd2;
  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
  localparam logic [7:0] C_DEF = 8'b11111_000;
  localparam logic [7:0] C_FRZ = 8'b00000_000;
  localparam logic [7:0] C_MD  = 8'b00011_001;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  localparam logic [7:0] C_RST = 8'b00000_111;
  logic [MDW-1:0] md_cnt, md_nxt;
  logic [1:0] nxt;
  logic [7:0] ctl, run_ctl;
  logic load_use, frz;
  always_comb begin
    load_use = ex_mem_read && ex_rt != '0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    run_ctl = md_start ? C_MD : ex_branch_taken ? C_BR : load_use ? C_LU : C_DEF;
    frz = state == MEM_WAIT ? !mem_ready : mem_access && !mem_ready;
    if (state == MD_WAIT) begin
      ctl = md_cnt != '0 ? C_MD : C_DEF;
      nxt = md_cnt != '0 ? MD_WAIT : RUN;
      md_nxt = md_cnt != '0 ? md_cnt - 1'b1 : '0;
    end else begin
      ctl = frz ? C_FRZ : run_ctl;
      nxt = frz ? MEM_WAIT : md_start ? MD_WAIT : RUN;
      md_nxt = !frz && md_start ? MD_INIT : md_cnt;
    end
  end
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush} = RSTn ? ctl : C_RST;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= RUN;
      md_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= nxt;
      md_cnt <= md_nxt;
      if (!ctl[7] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a queue-based scoreboard for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;
  localparam logic [7:0] DEF = 8'b11111_000, FRZ = 8'b00000_000, MD = 8'b00011_001;
  localparam logic [7:0] BR = 8'b11111_110, LU = 8'b00111_010, RST = 8'b00000_111;
  logic CLK = 0, RSTn = 1;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic id_uses_rt = 0, ex_mem_read = 0, ex_branch_taken = 0, md_start = 0, mem_access = 0, mem_ready = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush;
  logic pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2, ifid_flush2, idex_flush2, exmem_flush2;
  logic [15:0] stall_cnt;
  logic [1:0] sat_cnt, state, state2;
  exp_t q[$];
  int tests = 0, fails = 0, row = 0;
  always #5 CLK = ~CLK;
  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16), .REG_W(5)) dut (
    .CLK(CLK), .RSTn(RSTn), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .md_start(md_start),
    .mem_access(mem_access), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .stall_cnt(stall_cnt), .state(state));
  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(2), .REG_W(5)) sat (
    .CLK(CLK), .RSTn(RSTn), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .md_start(md_start),
    .mem_access(mem_access), .mem_ready(mem_ready), .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2),
    .exmem_en(exmem_en2), .memwb_en(memwb_en2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
    .exmem_flush(exmem_flush2), .stall_cnt(sat_cnt), .state(state2));
  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic [4:0] er, input logic mr, input logic br, input logic md,
                     input logic ma, input logic rdy, input logic [7:0] ec, input logic [1:0] es, input int n);
    exp_t e;
    @(posedge CLK);
    #1;
    RSTn = r; id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_rt = er;
    ex_mem_read = mr; ex_branch_taken = br; md_start = md; mem_access = ma; mem_ready = rdy;
    e.ctl = ec; e.st = es; e.cnt = 16'(n); e.sat = n > 3 ? 2'd3 : 2'(n);
    q.push_back(e);
  endtask
  always @(negedge CLK) begin
    exp_t e;
    logic [7:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      row++;
      tests++;
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
      if (act !== e.ctl || state !== e.st || stall_cnt !== e.cnt || sat_cnt !== e.sat) begin
        fails++;
        $display("FAIL row%0d: ctl=%b st=%0d cnt=%0d sat=%0d, want ctl=%b st=%0d cnt=%0d sat=%0d",
                 row, act, state, stall_cnt, sat_cnt, e.ctl, e.st, e.cnt, e.sat);
      end
    end
  end
  initial begin
    // reset held 3 cycles, then idle
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0);
    // load-use on rs, on rt, and non-hazards
    cyc(1, 8, 0, 0, 8, 1, 0, 0, 0, 0, LU, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1);
    cyc(1, 3, 9, 1, 9, 1, 0, 0, 0, 0, LU, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, DEF, 0, 2);
    cyc(1, 4, 9, 0, 9, 1, 0, 0, 0, 0, DEF, 0, 2);
    cyc(1, 8, 0, 0, 8, 0, 0, 0, 0, 0, DEF, 0, 2);
    // branch beats load-use
    cyc(1, 8, 0, 0, 8, 1, 1, 0, 0, 0, BR, 0, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 2);
    // mult/div held: 4 stall cycles, release on 5th
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD, 0, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, MD, 1, 3);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, MD, 1, 4);
    cyc(1, 8, 0, 0, 8, 1, 0, 1, 0, 0, MD, 1, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, DEF, 1, 6);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 6);
    // memory ready immediately: no stall
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, 0, 6);
    // 3 memory freezes, then md issue on ready
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 6);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 2, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 2, 8);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, MD, 2, 9);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, MD, 1, 10);
    // async reset in second MD_WAIT cycle
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 0);
    // memory wait released together with a taken branch
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, BR, 2, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1);
    @(negedge CLK);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
